if_stage: RTL
=============

// Module: if_stage
// PURPOSE
// Instruction fetch stage: drives the instruction-memory bus (req/gnt/rvalid, in-order responses).
// Buffers fetched words in a small prefetch FIFO and presents {pc, instr, valid} to the ID stage.
// Redirects the fetch on jumps resolved in ID and taken branches resolved in EX, discarding stale responses.
// PARAMETERS
// BOOT_ADDR  32'h0000_0000  first fetch address after reset (bits[1:0] must be 0)
// DEPTH      2              prefetch FIFO entries = max in-flight + buffered words; power of two, >= 2
// PORTS
// clk_i               in   1   clock
// rst_n_i             in   1   reset, asynchronous, active-low
// instr_req_o         out  1   fetch request
// instr_addr_o        out  32  fetch address, bits[1:0] always 0
// instr_gnt_i         in   1   request accepted this cycle
// instr_rvalid_i      in   1   response valid (in order, >= 1 cycle after gnt)
// instr_rdata_i       in   32  response data
// pc_if_o             out  32  PC of presented instruction
// instr_if_o          out  32  presented instruction
// valid_if_o          out  1   pc_if_o/instr_if_o valid
// stall_if_i          in   1   ID not accepting; no pop this cycle
// jump_id_i           in   1   jump in ID, redirect to jump_target_id_i
// jump_target_id_i    in   32  jump target
// branch_taken_ex_i   in   1   taken branch in EX, redirect to branch_target_ex_i
// branch_target_ex_i  in   32  branch target
// BEHAVIOUR
// - Reset values: instr_req_o=0, instr_addr_o=BOOT_ADDR, pc_if_o=0, instr_if_o=32'h0000_0013 (NOP),
//   valid_if_o=0. FIFO empty, in-flight=0, discard=0, FSM=IDLE.
// - FSM IDLE: req low for one cycle after reset deassertion, then -> FETCH.
// - FSM FETCH: req=1 while (in_flight + fifo_count) < DEPTH.
//   On gnt: addr += 4, in_flight++.
// - FSM HOLD: entered when a redirect occurs while req=1 && !gnt.
//   req and addr are held stable (bus rule) until gnt. That grant is counted as discard.
//   Then addr <= saved target and -> FETCH. A further redirect in HOLD overwrites the saved target.
// - Response: on rvalid, in_flight--. If discard>0: discard--, data dropped.
//   Otherwise push {rsp_pc, rdata} and rsp_pc += 4.
// - Output: valid_if_o = !fifo_empty. pc_if_o/instr_if_o = FIFO head (NOP/0 when empty).
//   Pop when valid_if_o && !stall_if_i. Combinational from FIFO state; zero added latency.
//   First instruction is valid the cycle after its rvalid.
// - Redirect (jump_id_i || branch_taken_ex_i): target = branch_target_ex_i if branch_taken_ex_i
//   (older instruction wins), else jump_target_id_i.
//   Target bits[1:0] are cleared. Same cycle: FIFO flushed, rsp_pc <= target.
//   discard <= in_flight (+1 if gnt this cycle, -1 if rvalid this cycle). Pop ignored.
//   In FETCH, the next cycle's addr = target.
// - Same-cycle rvalid and redirect: that response is dropped.
//   Same-cycle push and pop on a full FIFO are legal.
// - All arithmetic mod 2^32; addr wraps 0xFFFF_FFFC -> 0.
// - Counters are sized $clog2(DEPTH)+1. in_flight never exceeds DEPTH. FIFO never overflows (credit rule).
// - Reset mid-operation clears all state. Responses arriving after reset are ignored while in_flight=0.
// STRUCTURE
// - core_pkg gets fetch_state_t {IDLE, FETCH, HOLD} and localparam NOP_INSTR = 32'h0000_0013.
// - Sub-module prefetch_fifo (#DEPTH, WIDTH=64): push/pop/flush, full/empty/count, head data.
// - if_stage holds the FSM, address/rsp_pc registers, and the in-flight/discard counters.
// TESTING
// 1 BOOT_ADDR=0x80, gnt=1, rvalid 1 cycle after gnt -> addr 0x80,0x84,0x88 on consecutive cycles;
//   valid_if_o with pc 0x80,0x84,0x88 back-to-back.
// 2 stall_if_i=1 for 5 cycles -> req drops once in_flight+count=2; pc_if_o/instr_if_o stable;
//   no word lost or duplicated after release.
// 3 jump_id_i target 0x200 with 2 responses in flight -> both dropped; next valid pc=0x200.
// 4 branch_taken_ex_i(0x300) and jump_id_i(0x400) same cycle -> next valid pc=0x300.
// 5 redirect to 0x500 while req high, gnt low 3 cycles -> addr held until gnt, that word dropped,
//   then addr=0x500.
// 6 jump target 0x203 -> instr_addr_o=0x200, pc_if_o=0x200. Reset mid-fetch -> outputs at reset values.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
package core_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small prefetch FIFO with combinational head; flush wins over push/pop.
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !flush;
  assign do_pop    = pop && (cnt != '0) && !flush;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction bus, buffers responses and
// presents {pc, instr, valid} to decode, redirecting on jumps and taken branches.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] pc_if_o,
  output logic [31:0] instr_if_o,
  output logic        valid_if_o,
  input  logic        stall_if_i,
  input  logic        jump_id_i,
  input  logic [31:0] jump_target_id_i,
  input  logic        branch_taken_ex_i,
  input  logic [31:0] branch_target_ex_i
);
  import core_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  fetch_state_t  state, state_next;
  logic [31:0]   addr, addr_next;
  logic [31:0]   saved_target, saved_target_next;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] in_flight, discard, fifo_count;
  logic [UW-1:0] used;
  logic          credit_ok;
  logic          redirect, granted, rsp, push, pop;
  logic          fifo_empty, fifo_full;
  logic [31:0]   target;
  logic [63:0]   head;

  assign redirect     = jump_id_i || branch_taken_ex_i;
  assign target       = word_align(branch_taken_ex_i ? branch_target_ex_i : jump_target_id_i);
  assign valid_if_o   = !fifo_empty;
  assign pop          = valid_if_o && !stall_if_i && !redirect;
  // Responses with nothing outstanding (e.g. leftovers from before reset) are ignored.
  assign rsp          = instr_rvalid_i && (in_flight != '0);
  assign push         = rsp && (discard == '0) && !redirect && (!fifo_full || pop);
  assign granted      = instr_req_o && instr_gnt_i;
  assign instr_addr_o = addr;
  assign pc_if_o      = fifo_empty ? 32'h0 : head[63:32];
  assign instr_if_o   = fifo_empty ? NOP_INSTR : head[31:0];

  // The word leaving the FIFO this cycle frees its slot, keeping a
  // single-cycle memory streaming at one word per cycle.
  assign used      = UW'(in_flight) + UW'(fifo_count) - UW'(pop);
  assign credit_ok = (used < UW'(DEPTH));

  always_comb begin
    state_next        = state;
    addr_next         = addr;
    saved_target_next = saved_target;
    instr_req_o       = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) addr_next = target;
      end
      FETCH: begin
        instr_req_o = credit_ok;
        if (redirect && credit_ok && !instr_gnt_i) begin
          state_next        = HOLD;
          saved_target_next = target;
        end else if (redirect) begin
          addr_next = target;
        end else if (credit_ok && instr_gnt_i) begin
          addr_next = addr + 32'd4;
        end
      end
      HOLD: begin
        // An un-granted request must stay on the bus unchanged.
        instr_req_o = 1'b1;
        if (redirect) saved_target_next = target;
        if (instr_gnt_i) begin
          state_next = FETCH;
          addr_next  = redirect ? target : saved_target;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      addr         <= BOOT_ADDR;
      saved_target <= BOOT_ADDR;
      rsp_pc       <= BOOT_ADDR;
      in_flight    <= '0;
      discard      <= '0;
    end else begin
      state        <= state_next;
      addr         <= addr_next;
      saved_target <= saved_target_next;
      in_flight    <= in_flight + CW'(granted) - CW'(rsp);
      if (redirect) begin
        rsp_pc  <= target;
        discard <= in_flight + CW'(granted) - CW'(rsp);
      end else begin
        if (push) rsp_pc <= rsp_pc + 32'd4;
        // The request held across a redirect returns stale data.
        discard <= discard + CW'(state == HOLD && instr_gnt_i)
                           - CW'(rsp && (discard != '0));
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data ({rsp_pc, instr_rdata_i}),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
